// File: rtl/button_debouncer.sv
// Push-button front end: two-flop synchroniser, edge debouncer FSM, press/release/
// long-press pulses and a wrapping press counter. All outputs are registered.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLD_CYCLES     = 50000000,
  parameter int COUNT_W         = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               BTN,
  output logic               BTN_LEVEL,
  output logic               PRESS_PULSE,
  output logic               RELEASE_PULSE,
  output logic               LONG_PRESS,
  output logic [COUNT_W-1:0] PRESS_COUNT
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int HW = $clog2(HOLD_CYCLES) + 1;
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {S_LOW, S_RISE, S_HIGH, S_FALL} state_t;

  state_t        state;
  logic          sync1, sync2;
  logic [DW-1:0] deb_cnt;
  logic [HW-1:0] hold_cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= S_LOW;
      sync1         <= 1'b0;
      sync2         <= 1'b0;
      deb_cnt       <= '0;
      hold_cnt      <= '0;
      BTN_LEVEL     <= 1'b0;
      PRESS_PULSE   <= 1'b0;
      RELEASE_PULSE <= 1'b0;
      LONG_PRESS    <= 1'b0;
      PRESS_COUNT   <= '0;
    end else begin
      sync1         <= BTN;
      sync2         <= sync1;
      PRESS_PULSE   <= 1'b0;
      RELEASE_PULSE <= 1'b0;
      LONG_PRESS    <= 1'b0;
      case (state)
        S_LOW: begin
          if (sync2) begin
            state   <= S_RISE;
            deb_cnt <= '0;
          end
        end
        S_RISE: begin
          if (!sync2) begin
            state <= S_LOW;
          end else if (deb_cnt == DEB_LAST) begin
            state       <= S_HIGH;
            BTN_LEVEL   <= 1'b1;
            PRESS_PULSE <= 1'b1;
            PRESS_COUNT <= PRESS_COUNT + 1'b1;
            hold_cnt    <= '0;
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end
        S_HIGH: begin
          if (!sync2) begin
            state   <= S_FALL;
            deb_cnt <= '0;
          end
          // Saturating hold counter: LONG_PRESS can only fire once per press.
          if (hold_cnt < HOLD_MAX) begin
            hold_cnt <= hold_cnt + 1'b1;
            if (hold_cnt == HOLD_LAST) LONG_PRESS <= 1'b1;
          end
        end
        S_FALL: begin
          if (sync2 || deb_cnt != DEB_LAST) begin
            if (sync2) state <= S_HIGH;
            else       deb_cnt <= deb_cnt + 1'b1;
            // Release bounces keep the hold timer running rather than re-arming it.
            if (hold_cnt < HOLD_MAX) begin
              hold_cnt <= hold_cnt + 1'b1;
              if (hold_cnt == HOLD_LAST) LONG_PRESS <= 1'b1;
            end
          end else begin
            state         <= S_LOW;
            BTN_LEVEL     <= 1'b0;
            RELEASE_PULSE <= 1'b1;
            hold_cnt      <= '0;
          end
        end
        default: state <= S_LOW;
      endcase
    end
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: directed scenarios plus random bouncing, every cycle
// compared against a run-length reference model of the debounced button.
module tb_button_debouncer;
  localparam int D = 4;
  localparam int H = 10;

  logic       CLK, RST, BTN;
  logic       BTN_LEVEL, PRESS_PULSE, RELEASE_PULSE, LONG_PRESS;
  logic [7:0] PRESS_COUNT;

  button_debouncer #(.DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .COUNT_W(8)) dut (
    .CLK(CLK), .RST(RST), .BTN(BTN),
    .BTN_LEVEL(BTN_LEVEL), .PRESS_PULSE(PRESS_PULSE), .RELEASE_PULSE(RELEASE_PULSE),
    .LONG_PRESS(LONG_PRESS), .PRESS_COUNT(PRESS_COUNT)
  );

  initial CLK = 1'b0;
  always #10 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // Reference model: the button is seen two cycles late; the level flips once
  // D+1 consecutive late samples disagree with it; long press fires H cycles after a press.
  logic       m_s1, m_s2, m_lvl, m_pp, m_rp, m_lp;
  logic [7:0] m_cnt;
  int         m_run, m_since;

  logic [11:0] dut_v, mdl_v;
  assign dut_v = {BTN_LEVEL, PRESS_PULSE, RELEASE_PULSE, LONG_PRESS, PRESS_COUNT};
  assign mdl_v = {m_lvl, m_pp, m_rp, m_lp, m_cnt};

  task automatic model_step(input logic b, input logic r);
    logic s;
    if (r) begin
      m_s1 = 0; m_s2 = 0; m_lvl = 0; m_pp = 0; m_rp = 0; m_lp = 0;
      m_cnt = 0; m_run = 0; m_since = 0;
    end else begin
      s = m_s2;
      m_s2 = m_s1;
      m_s1 = b;
      m_pp = 0; m_rp = 0; m_lp = 0;
      if (s != m_lvl) m_run++;
      else            m_run = 0;
      if (m_run == D + 1) begin
        m_run = 0;
        m_lvl = s;
        if (s) begin m_pp = 1; m_cnt++; m_since = 0; end
        else   m_rp = 1;
      end else if (m_lvl) begin
        m_since++;
        if (m_since == H) m_lp = 1;
      end
    end
  endtask

  // Drive inputs for the next rising edge, step the model, then sample at the falling edge.
  task automatic tick(input logic b, input logic r);
    BTN = b;
    RST = r;
    model_step(b, r);
    @(negedge CLK);
  endtask

  task automatic test_reset();
    tick(1, 1);
    tick(1, 1);
    total++;
    if (dut_v !== 12'h000) begin
      bad++; $display("FAIL reset_zero: got %h want %h", dut_v, 12'h000);
    end
    for (int i = 1; i <= 8; i++) begin
      tick(1, 0);
      total++;
      if (PRESS_PULSE !== (i == 7)) begin
        bad++; $display("FAIL reset_press_edge %0d: got %b want %b", i, PRESS_PULSE, (i == 7));
      end
      total++;
      if (dut_v !== mdl_v) begin
        bad++; $display("FAIL reset_model %0d: got %h want %h", i, dut_v, mdl_v);
      end
    end
    total++;
    if (PRESS_COUNT !== 8'd1) begin
      bad++; $display("FAIL reset_count: got %0d want 1", PRESS_COUNT);
    end
  endtask

  task automatic test_clean();
    for (int i = 1; i <= 8; i++) begin
      tick(0, 0);
      total++;
      if (RELEASE_PULSE !== (i == 7) || BTN_LEVEL !== (i < 7)) begin
        bad++; $display("FAIL clean_release %0d: got rp=%b lvl=%b want rp=%b lvl=%b",
                        i, RELEASE_PULSE, BTN_LEVEL, (i == 7), (i < 7));
      end
    end
    for (int i = 1; i <= 8; i++) begin
      tick(1, 0);
      total++;
      if (PRESS_PULSE !== (i == 7) || BTN_LEVEL !== (i >= 7)) begin
        bad++; $display("FAIL clean_press %0d: got pp=%b lvl=%b want pp=%b lvl=%b",
                        i, PRESS_PULSE, BTN_LEVEL, (i == 7), (i >= 7));
      end
      total++;
      if (dut_v !== mdl_v) begin
        bad++; $display("FAIL clean_model %0d: got %h want %h", i, dut_v, mdl_v);
      end
    end
    for (int i = 1; i <= 8; i++) begin
      tick(0, 0);
      total++;
      if (dut_v !== mdl_v) begin
        bad++; $display("FAIL clean_model_rel %0d: got %h want %h", i, dut_v, mdl_v);
      end
    end
    total++;
    if (PRESS_COUNT !== 8'd2) begin
      bad++; $display("FAIL clean_count: got %0d want 2", PRESS_COUNT);
    end
  endtask

  task automatic test_bounce();
    logic       lv [5]  = '{1, 0, 1, 0, 1};
    int         len [5] = '{4, 2, 3, 10, 5};
    int         pp = 0, rp = 0;
    logic [7:0] c0 = m_cnt;
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < len[k]; j++) begin
        tick(lv[k], 0);
        pp += PRESS_PULSE; rp += RELEASE_PULSE;
        total++;
        if (dut_v !== mdl_v) begin
          bad++; $display("FAIL bounce_model: got %h want %h", dut_v, mdl_v);
        end
      end
    total++;
    if (pp != 0 || rp != 0 || PRESS_COUNT !== c0) begin
      bad++; $display("FAIL bounce_reject: got pp=%0d rp=%0d cnt=%0d want 0 0 %0d", pp, rp, PRESS_COUNT, c0);
    end
    for (int j = 0; j < 17; j++) begin
      tick(j < len[4], 0);
      pp += PRESS_PULSE; rp += RELEASE_PULSE;
      total++;
      if (dut_v !== mdl_v) begin
        bad++; $display("FAIL bounce_model2: got %h want %h", dut_v, mdl_v);
      end
    end
    total++;
    if (pp != 1 || rp != 1 || PRESS_COUNT !== c0 + 8'd1) begin
      bad++; $display("FAIL bounce_accept: got pp=%0d rp=%0d cnt=%0d want 1 1 %0d", pp, rp, PRESS_COUNT, c0 + 8'd1);
    end
  endtask

  task automatic test_long();
    int pp_t = -1, lp_t = -1, lp = 0, rp = 0;
    for (int t = 0; t < 55; t++) begin
      tick((t < 20) || (t >= 23 && t < 43), 0);
      if (PRESS_PULSE) pp_t = t;
      if (LONG_PRESS) begin lp++; lp_t = t; end
      if (RELEASE_PULSE && t < 43) rp++;
      total++;
      if (dut_v !== mdl_v) begin
        bad++; $display("FAIL long_model %0d: got %h want %h", t, dut_v, mdl_v);
      end
    end
    total++;
    if (lp != 1 || lp_t - pp_t != H || rp != 0 || BTN_LEVEL !== 1'b0) begin
      bad++; $display("FAIL long_press: got lp=%0d dt=%0d early_rp=%0d lvl=%b want 1 %0d 0 0",
                      lp, lp_t - pp_t, rp, BTN_LEVEL, H);
    end
  endtask

  task automatic test_reset_mid();
    int lp = 0;
    for (int i = 0; i < 4; i++) tick(1, 0);
    tick(0, 1);
    total++;
    if (dut_v !== 12'h000) begin
      bad++; $display("FAIL rst_rise: got %h want %h", dut_v, 12'h000);
    end
    for (int i = 0; i < 4; i++) tick(0, 0);
    for (int i = 0; i < 12; i++) begin
      tick(1, 0);
      total++;
      if (dut_v !== mdl_v) begin
        bad++; $display("FAIL rst_mid_model %0d: got %h want %h", i, dut_v, mdl_v);
      end
    end
    tick(0, 1);
    total++;
    if (dut_v !== 12'h000) begin
      bad++; $display("FAIL rst_high: got %h want %h", dut_v, 12'h000);
    end
    for (int i = 0; i < 20; i++) begin
      tick(0, 0);
      lp += LONG_PRESS;
    end
    total++;
    if (lp != 0 || dut_v !== 12'h000) begin
      bad++; $display("FAIL rst_no_long: got lp=%0d v=%h want 0 000", lp, dut_v);
    end
  endtask

  task automatic test_wrap();
    int pp = 0;
    tick(0, 1);
    for (int n = 0; n < 256; n++)
      for (int t = 0; t < 16; t++) begin
        tick(t < 8, 0);
        pp += PRESS_PULSE;
        total++;
        if (dut_v !== mdl_v) begin
          bad++; $display("FAIL wrap_model %0d/%0d: got %h want %h", n, t, dut_v, mdl_v);
        end
      end
    total++;
    if (pp != 256 || PRESS_COUNT !== 8'h00) begin
      bad++; $display("FAIL wrap: got pulses=%0d cnt=%h want 256 00", pp, PRESS_COUNT);
    end
  endtask

  task automatic test_random();
    logic b = 0;
    int   run = 0;
    for (int t = 0; t < 3000; t++) begin
      if (run == 0) begin
        b   = ~b;
        run = $urandom_range(1, 14);
      end
      run--;
      tick(b, ($urandom_range(0, 299) == 0));
      total++;
      if (dut_v !== mdl_v) begin
        bad++; $display("FAIL random_model %0d: got %h want %h", t, dut_v, mdl_v);
      end
    end
  endtask

  initial begin
    BTN = 1'b0;
    RST = 1'b1;
    test_reset();
    test_clean();
    test_bounce();
    test_long();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
